// File: rtl/regbank_pkg.sv
// Shared definitions for the register-bank write-port arbiter.
//   RB_AW / RB_DW / RB_NREGS : register bank geometry
//   wr_req_t                 : one pending write (address + data)
//   REQ_ALU / REQ_MEM        : requester indices (ALU result, memory load)
package regbank_pkg;

    localparam int unsigned RB_AW    = 5;
    localparam int unsigned RB_DW    = 32;
    localparam int unsigned RB_NREGS = 32;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_MEM = 1;

    typedef struct packed {
        logic [RB_AW-1:0] addr;
        logic [RB_DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regbank_hold_slot.sv
// One-entry holding register behind a valid/ready handshake.
//   clk, rst  : clock, synchronous active-high reset (empties the slot)
//   load      : capture din (only asserted when ready_c is high)
//   free      : entry is issued this cycle
//   din/dout  : payload in / held payload
//   valid     : slot occupied
//   ready_c   : slot can accept this cycle (empty or being freed); 0 in reset
module regbank_hold_slot
    import regbank_pkg::*;
#(
    parameter type T = wr_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic free,
    input  T     din,
    output logic valid,
    output T     dout,
    output logic ready_c
);

    // Freeing and loading on the same edge keeps the slot occupied with new data.
    assign ready_c = !rst && (!valid || free);

    // Occupancy and payload register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (free) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regbank_wr_arbiter.sv
// Shares the single register-bank write port between the ALU writeback
// (req0) and the memory-load writeback (req1).
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/addr/data/ready    : per-requester valid/ready write request
//   dir_wra, di, reg_wr           : registered bank write port
//   pending                       : occupied holding registers after the edge
//   fwd_{a,b}_addr/hit/data       : read-address bypass lookup
// Optional feature macro: REGWR_BYPASS_EN enables the bypass lookup; without
// it the fwd_* outputs are tied to zero and fwd_*_addr are ignored.
module regbank_wr_arbiter
    import regbank_pkg::*;
#(
    parameter int unsigned AW      = $clog2(RB_NREGS),
    parameter int unsigned DW      = RB_DW,
    parameter bit          DROP_R0 = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [AW-1:0] dir_wra,
    output logic [DW-1:0] di,
    output logic          reg_wr,
    output logic [1:0]    pending,
    input  logic [AW-1:0] fwd_a_addr,
    input  logic [AW-1:0] fwd_b_addr,
    output logic          fwd_a_hit,
    output logic          fwd_b_hit,
    output logic [DW-1:0] fwd_a_data,
    output logic [DW-1:0] fwd_b_data
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } slot_t;

    localparam bit IDX_ALU = 1'(REQ_ALU);
    localparam bit IDX_MEM = 1'(REQ_MEM);

    slot_t       in0, in1, h0, h1, win;
    logic        v0, v1;
    logic        rdy0, rdy1, load0, load1;
    logic [1:0]  gnt;
    logic        rr_ptr, rr_nxt;
    logic        age, age_nxt;     // index of the younger entry when both are held
    logic        wr_nxt;
    logic        occ0_nxt, occ1_nxt;
    logic [1:0]  pend_nxt;

    assign in0 = '{addr: req0_addr, data: req0_data};
    assign in1 = '{addr: req1_addr, data: req1_data};

    assign load0      = req0_valid && rdy0;
    assign load1      = req1_valid && rdy1;
    assign req0_ready = rdy0;
    assign req1_ready = rdy1;

    regbank_hold_slot #(.T(slot_t)) u_hold0 (
        .clk     (clk),
        .rst     (rst),
        .load    (load0),
        .free    (gnt[IDX_ALU]),
        .din     (in0),
        .valid   (v0),
        .dout    (h0),
        .ready_c (rdy0)
    );

    regbank_hold_slot #(.T(slot_t)) u_hold1 (
        .clk     (clk),
        .rst     (rst),
        .load    (load1),
        .free    (gnt[IDX_MEM]),
        .din     (in1),
        .valid   (v1),
        .dout    (h1),
        .ready_c (rdy1)
    );

    // Grant: lone entry wins; two entries use round-robin, except that a
    // same-address pair issues the older one first so the younger value lands last.
    always_comb begin : grant_comb
        gnt    = 2'b00;
        rr_nxt = rr_ptr;
        if (v0 && v1) begin
            rr_nxt = ~rr_ptr;
            if (h0.addr == h1.addr) begin
                gnt = age ? 2'b01 : 2'b10;
            end else begin
                gnt = rr_ptr ? 2'b10 : 2'b01;
            end
        end else if (v0) begin
            gnt = 2'b01;
        end else if (v1) begin
            gnt = 2'b10;
        end
    end

    // Age tracking, issue decision and next occupancy.
    always_comb begin : next_comb
        age_nxt = age;
        if (load0 && load1) begin
            age_nxt = IDX_MEM;
        end else if (load0 && v1 && !gnt[IDX_MEM]) begin
            age_nxt = IDX_ALU;
        end else if (load1 && v0 && !gnt[IDX_ALU]) begin
            age_nxt = IDX_MEM;
        end

        win      = gnt[IDX_MEM] ? h1 : h0;
        wr_nxt   = (gnt != 2'b00) && !(DROP_R0 && (win.addr == '0));
        occ0_nxt = load0 || (v0 && !gnt[IDX_ALU]);
        occ1_nxt = load1 || (v1 && !gnt[IDX_MEM]);
        pend_nxt = {1'b0, occ0_nxt} + {1'b0, occ1_nxt};
    end

    // Arbiter state and registered write port; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= 1'b0;
            age     <= 1'b0;
            reg_wr  <= 1'b0;
            dir_wra <= '0;
            di      <= '0;
            pending <= 2'b00;
        end else begin
            rr_ptr  <= rr_nxt;
            age     <= age_nxt;
            reg_wr  <= wr_nxt;
            pending <= pend_nxt;
            if (wr_nxt) begin
                dir_wra <= win.addr;
                di      <= win.data;
            end
        end
    end

`ifdef REGWR_BYPASS_EN
    // Youngest match wins: younger held entry, older held entry, then the port.
    function automatic logic [DW:0] fwd_lookup(input logic [AW-1:0] a);
        logic          m0, m1, mp;
        logic [DW-1:0] d;
        m0 = v0 && (h0.addr == a);
        m1 = v1 && (h1.addr == a);
        mp = reg_wr && (dir_wra == a);
        if (DROP_R0 && (a == '0)) begin
            m0 = 1'b0;
            m1 = 1'b0;
            mp = 1'b0;
        end
        d = '0;
        if (m0 && m1) begin
            d = age ? h1.data : h0.data;
        end else if (m0) begin
            d = h0.data;
        end else if (m1) begin
            d = h1.data;
        end else if (mp) begin
            d = di;
        end
        return {m0 || m1 || mp, d};
    endfunction

    assign {fwd_a_hit, fwd_a_data} = fwd_lookup(fwd_a_addr);
    assign {fwd_b_hit, fwd_b_data} = fwd_lookup(fwd_b_addr);
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{fwd_a_addr, fwd_b_addr};
    assign fwd_a_hit  = 1'b0;
    assign fwd_b_hit  = 1'b0;
    assign fwd_a_data = '0;
    assign fwd_b_data = '0;
`endif

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
- Shares the single write port of the 32x32 register bank (dir_wra/di/reg_wr) between two writeback requesters: req0 = ALU result, req1 = memory load.
- Each requester has a 1-entry holding register behind a valid/ready handshake.
- Round-robin grant with age ordering for same-address conflicts; registered write-port outputs.
- Sits between the execute/memory stages and the register bank; read ports (dir_a/dir_b/reg_rd) stay untouched.

Parameters:
- AW, 5, register address width (32 registers).
- DW, 32, data width.
- DROP_R0, 1, when 1, accepted writes to address 0 complete the handshake but never reach the bank.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  ALU write request.
- req0_addr  in  AW  ALU destination register.
- req0_data  in  DW  ALU write data.
- req0_ready  out  1  ALU holding register can accept.
- req1_valid/req1_addr/req1_data/req1_ready  same roles for the memory-load requester.
- dir_wra  out  AW  bank write address.
- di  out  DW  bank write data.
- reg_wr  out  1  bank write enable, one cycle per write.
- pending  out  2  number of occupied holding registers (0..2).
- fwd_a_addr, fwd_b_addr  in  AW  read addresses under check; used only with the optional feature.
- fwd_a_hit, fwd_b_hit  out  1  pending write matches the read address; optional feature.
- fwd_a_data, fwd_b_data  out  DW  youngest pending data for that address; optional feature.

Behaviour:
- Reset (synchronous, active-high):
  - Holding registers empty; rr_ptr=0 (req0 preferred); age flag cleared.
  - reg_wr=0, dir_wra=0, di=0, pending=0, fwd_*_hit=0, fwd_*_data=0.
  - Reset has priority over everything. Entries held when rst is asserted are discarded and never written. req*_ready is 0 during the rst cycle.
- Handshake:
  - reqN_ready = holdN empty OR holdN granted this cycle, which gives back-to-back throughput.
  - Transfer occurs when valid && ready at the rising edge.
  - Data is captured into holdN at that edge.
  - valid may drop without transfer (no stability rule on the requester side).
- Grant, evaluated combinationally each cycle on occupied entries:
  - One occupied entry: that entry is granted.
  - Both occupied, different addresses: the entry selected by rr_ptr is granted; rr_ptr then points to the other requester.
  - Both occupied, same address: the older entry is granted, per the age flag, regardless of rr_ptr; rr_ptr still toggles. This preserves program order for the last write.
  - Age flag: set to N when holdN is loaded while the other entry is already occupied and not being granted. If both are loaded on the same edge, req0 is treated as older.
- Issue:
  - The granted entry frees at the edge; dir_wra/di/reg_wr are registered at the same edge.
  - Latency: accept at edge E, reg_wr high in cycle E+1 to E+2, bank write at edge E+2, minimum. A lone requester achieves 1 write per cycle.
  - With DROP_R0=1 and address 0, the entry frees but reg_wr stays 0 for that slot.
- reg_wr is high for exactly one cycle per issued write. dir_wra/di hold their last value when reg_wr=0.
- pending is registered and reflects occupancy after the edge.
- Simultaneous accept into holdN and grant of holdN on the same edge: the new data replaces the issued entry, and the entry stays occupied.

Optional Feature:
- Macro: REGWR_BYPASS_EN.
- Defined:
  - fwd_x_hit=1 when any occupied holding entry, or the write currently driven on dir_wra with reg_wr=1, matches fwd_x_addr.
  - fwd_x_data returns the youngest match. Order, youngest first: holding by age, then the on-port write.
  - Address 0 never hits when DROP_R0=1.
  - Outputs are combinational from internal state.
- Not defined: fwd_*_hit and fwd_*_data are tied to 0; fwd_*_addr are ignored.

Decomposition:
- Shared package regbank_pkg:
  - RB_AW=5, RB_DW=32, RB_NREGS=32.
  - Typedef wr_req_t {addr, data}.
  - Requester index constants REQ_ALU=0, REQ_MEM=1.
- Sub-module regbank_hold_slot: one valid/ready holding register with load/free. Instantiate it twice.

Test Plan:
- Lone req0: writes r10=2, r11=5, r12=20 on consecutive cycles. Expect req0_ready held 1 throughout, reg_wr high for 3 consecutive cycles starting 1 cycle after first accept, and the three address/data pairs in order.
- Both valid, same cycle, different addresses: req0 r3=7, req1 r4=9. Expect r3 issued first then r4. Repeat both simultaneously: r4-side (req1) first this time.
- Same-address ordering: req1 r10=50 accepted at edge E, req0 r10=2 at E+1 while req1 still held. Expect r10=50 issued before r10=2.
- DROP_R0: req0 writes r0=99 then r5=1. Expect handshake for both, no reg_wr for r0, and reg_wr with dir_wra=5, di=1.
- Reset mid-operation: both entries occupied, assert rst for 1 cycle. Expect no reg_wr, pending=0 the next cycle, and ready high the cycle after rst deasserts.
- With REGWR_BYPASS_EN: hold r12=20 pending, fwd_a_addr=12. Expect fwd_a_hit=1, fwd_a_data=20; fwd_b_addr=13 gives hit=0.
